// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10,
        DONE    = 2'b11
    } state_t;

    localparam logic [15:0] BCD_MAX_MMSS = 16'h5959;
    localparam logic [15:0] BCD_ZERO     = 16'h0000;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/stopwatch_controller_if.sv
// Command/status bus between the stopwatch controller and the BCD counter datapath.
interface stopwatch_controller_if #(
    parameter int W = 16
) ();

    logic [W-1:0] count_value;
    logic         count_en;
    logic         up_down;
    logic         load;
    logic [W-1:0] load_value;

    modport master (
        input  count_value,
        output count_en,
        output up_down,
        output load,
        output load_value
    );

    modport slave (
        output count_value,
        input  count_en,
        input  up_down,
        input  load,
        input  load_value
    );

endinterface

// File: rtl/button_conditioner.sv
// Raw button -> 2-FF sync -> debounce -> one-cycle press pulse.
module button_conditioner
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          stable_q, stable_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Level is accepted only after it differs from the stable one for
    // DEBOUNCE_CYCLES consecutive cycles; a rising acceptance is the pulse.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        pulse_d  = 1'b0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync_q[1];
                pulse_d  = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b00;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], btn};
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM: buttons -> counter enable/direction/load, display, alarm.
// Optional lap-hold display freeze is built when STOPWATCH_LAP_HOLD_EN is defined.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int NUMBER_OF_DIGITS         = 4,
    parameter int NUMBER_OF_BITS_PER_DIGIT = 4,
    parameter int DEBOUNCE_CYCLES          = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    btn_start_stop,
    input  logic                    btn_clear,
    input  logic                    btn_lap,
    input  logic                    mode_up,
    input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] preset,
    stopwatch_controller_if.master  ctr,
    output logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] display_value,
    output logic                    alarm,
    output logic [1:0]              state_o
);

    localparam int W = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;

    logic ss_p, clr_p;

    state_t       state_q, state_d;
    logic         count_en_q, count_en_d;
    logic         up_down_q, up_down_d;
    logic         load_q, load_d;
    logic [W-1:0] load_value_q, load_value_d;
    logic [W-1:0] display_q, display_d;
    logic         alarm_q, alarm_d;
    logic         terminal;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_ss (
        .clk   (clk),
        .rst_n (rst),
        .btn   (btn_start_stop),
        .pulse (ss_p)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clr (
        .clk   (clk),
        .rst_n (rst),
        .btn   (btn_clear),
        .pulse (clr_p)
    );

`ifdef STOPWATCH_LAP_HOLD_EN
    logic lap_p;
    logic lap_hold_q, lap_hold_d;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
        .clk   (clk),
        .rst_n (rst),
        .btn   (btn_lap),
        .pulse (lap_p)
    );
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
`endif

    assign terminal = up_down_q ? (ctr.count_value == W'(BCD_MAX_MMSS))
                                : (ctr.count_value == W'(BCD_ZERO));

    always_comb begin
        state_d      = state_q;
        load_d       = 1'b0;
        load_value_d = load_value_q;
        up_down_d    = up_down_q;
`ifdef STOPWATCH_LAP_HOLD_EN
        lap_hold_d   = lap_hold_q;
`endif
        if (clr_p) begin
            state_d      = IDLE;
            load_d       = 1'b1;
            load_value_d = mode_up ? W'(BCD_ZERO) : preset;
`ifdef STOPWATCH_LAP_HOLD_EN
            lap_hold_d   = 1'b0;
`endif
        end else if (ss_p) begin
            unique case (state_q)
                IDLE: begin
                    if (mode_up || ctr.count_value != W'(BCD_ZERO))
                        state_d = RUNNING;
                end
                RUNNING: state_d = PAUSED;
                PAUSED:  state_d = RUNNING;
                DONE:    state_d = IDLE;
            endcase
        end else if (state_q == RUNNING && terminal) begin
            state_d = DONE;
`ifdef STOPWATCH_LAP_HOLD_EN
        end else if (lap_p) begin
            if (state_q == RUNNING)
                lap_hold_d = ~lap_hold_q;
            else
                lap_hold_d = 1'b0;
`endif
        end

        // Direction is latched everywhere except IDLE.
        if (state_q == IDLE)
            up_down_d = mode_up;

        count_en_d = (state_d == RUNNING);
        alarm_d    = (state_d == DONE);

`ifdef STOPWATCH_LAP_HOLD_EN
        if (state_d != RUNNING && state_d != PAUSED)
            lap_hold_d = 1'b0;
        display_d = lap_hold_d ? display_q : ctr.count_value;
`else
        display_d = ctr.count_value;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            count_en_q   <= 1'b0;
            up_down_q    <= 1'b1;
            load_q       <= 1'b0;
            load_value_q <= '0;
            display_q    <= '0;
            alarm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_en_q   <= count_en_d;
            up_down_q    <= up_down_d;
            load_q       <= load_d;
            load_value_q <= load_value_d;
            display_q    <= display_d;
            alarm_q      <= alarm_d;
        end
    end

`ifdef STOPWATCH_LAP_HOLD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lap_hold_q <= 1'b0;
        else
            lap_hold_q <= lap_hold_d;
    end
`endif

    assign ctr.count_en   = count_en_q;
    assign ctr.up_down    = up_down_q;
    assign ctr.load       = load_q;
    assign ctr.load_value = load_value_q;
    assign display_value  = display_q;
    assign alarm          = alarm_q;
    assign state_o        = state_q;

endmodule
